// File: rtl/multicycle_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_pkg
// Shared definitions for the multicycle RV32 control unit.
// This package defines:
//   - the opcode constants the controller decodes,
//   - the FSM state enum, whose encoding is also exported as the debug state,
//   - the datapath select encodings (pc_src, alu_src_a/b, alu_op, mem_to_reg),
//   - the fault codes,
//   - decode_target(), which maps an opcode to the state that follows DECODE.
// ---------------------------------------------------------------------------
package multicycle_pkg;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_EXEC    = 4'd2,
    ST_MEM_ACC = 4'd3,
    ST_WB      = 4'd4,
    ST_BRANCH  = 4'd5,
    ST_JUMP    = 4'd6,
    ST_HALT    = 4'd7
  } state_t;

  typedef enum logic [1:0] {
    PC_SRC_ALU      = 2'b00,
    PC_SRC_ALUOUT   = 2'b01,
    PC_SRC_ALU_LSB0 = 2'b10
  } pc_src_t;

  typedef enum logic [1:0] {
    SRC_A_PC     = 2'b00,
    SRC_A_OLD_PC = 2'b01,
    SRC_A_RS1    = 2'b10,
    SRC_A_ZERO   = 2'b11
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'b00,
    SRC_B_FOUR = 2'b01,
    SRC_B_IMM  = 2'b10
  } alu_src_b_t;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RTYPE  = 2'b10,
    ALU_ITYPE  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'b00,
    WB_MEM    = 2'b01,
    WB_LINK   = 2'b10
  } mem_to_reg_t;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_ILLEGAL = 2'b01,
    FAULT_TIMEOUT = 2'b10
  } fault_code_t;

  // State that follows DECODE for a given opcode; unknown opcodes halt.
  function automatic state_t decode_target(input logic [6:0] op);
    state_t st;
    case (op)
      OP_R_TYPE, OP_I_ALU, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE: st = ST_EXEC;
      OP_BRANCH:                                               st = ST_BRANCH;
      OP_JAL, OP_JALR:                                         st = ST_JUMP;
      default:                                                 st = ST_HALT;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// multicycle_controller_if
// Control/status bundle between the controller and the datapath/memory side.
//   master : controller  (inputs opcode, branch_cond, mem_ready; drives rest)
//   slave  : datapath    (mirror image)
// ---------------------------------------------------------------------------
interface multicycle_controller_if #(
  parameter int CNT_W = 32
) ();

  logic [6:0]       opcode;
  logic             branch_cond;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             addr_sel;
  logic             ir_write;
  logic             pc_write;
  logic             reg_write;
  logic [1:0]       pc_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       mem_to_reg;
  logic             fault;
  logic [1:0]       fault_code;
  logic [CNT_W-1:0] instret;
  logic [3:0]       state;

  modport master (
    input  opcode, branch_cond, mem_ready,
    output mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write,
           pc_src, alu_src_a, alu_src_b, alu_op, mem_to_reg,
           fault, fault_code, instret, state
  );

  modport slave (
    output opcode, branch_cond, mem_ready,
    input  mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write,
           pc_src, alu_src_a, alu_src_b, alu_op, mem_to_reg,
           fault, fault_code, instret, state
  );

endinterface

// File: rtl/mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles a memory access has waited without mem_ready.
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the count (asserted when the FSM changes state)
//   count      : a waiting cycle with no mem_ready
//   timeout    : this waiting cycle is the MEM_TIMEOUT-th one without ready
// A cycle that sees mem_ready does not count, so a ready arriving on the last
// permitted cycle still completes the access.
// ---------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic timeout
);

  localparam int            CW   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt_r;

  // Wait-cycle counter; saturates at LAST because the FSM leaves on timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (count && (cnt_r != LAST)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign timeout = count && (cnt_r == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// FSM control unit for a multicycle RV32 datapath
// (FETCH/DECODE/EXEC/MEM_ACC/WB/BRANCH/JUMP/HALT).
//   clk, reset : clock, synchronous active-high reset
//   bus        : multicycle_controller_if.master
//                inputs  : opcode, branch_cond, mem_ready
//                outputs : strobes and selects, fault, fault_code,
//                          instret, state
// The strobes and selects are decoded from the current state, and also from
// mem_ready and branch_cond, so that ir_write/pc_write can fire in the same
// cycle as the memory completion. All of them read 0 while reset is high.
// ---------------------------------------------------------------------------
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic                    clk,
  input logic                    reset,
  multicycle_controller_if.master bus
);

  state_t           state_r, state_next_s;
  logic             retire_s, fault_set_s;
  fault_code_t      fault_code_next_s, fault_code_r;
  logic             fault_r;
  logic [CNT_W-1:0] instret_r;
  logic             wait_en_s, timer_clear_s, timeout_s;

  assign wait_en_s     = !reset && !bus.mem_ready &&
                         ((state_r == ST_FETCH) || (state_r == ST_MEM_ACC));
  assign timer_clear_s = reset || (state_next_s != state_r);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear_s),
    .count   (wait_en_s),
    .timeout (timeout_s)
  );

  // Next-state and output decode; everything defaults to 0 / hold.
  always_comb begin
    state_next_s      = state_r;
    retire_s          = 1'b0;
    fault_set_s       = 1'b0;
    fault_code_next_s = FAULT_NONE;
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.addr_sel      = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.reg_write     = 1'b0;
    bus.pc_src        = PC_SRC_ALU;
    bus.alu_src_a     = SRC_A_PC;
    bus.alu_src_b     = SRC_B_RS2;
    bus.alu_op        = ALU_ADD;
    bus.mem_to_reg    = WB_ALUOUT;
    if (reset) begin
      state_next_s = ST_FETCH;
    end else begin
      case (state_r)
        ST_FETCH: begin
          bus.mem_req   = 1'b1;
          bus.alu_src_b = SRC_B_FOUR;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            state_next_s = ST_DECODE;
          end else if (timeout_s) begin
            state_next_s      = ST_HALT;
            fault_set_s       = 1'b1;
            fault_code_next_s = FAULT_TIMEOUT;
          end else begin
            state_next_s = ST_FETCH;
          end
        end
        ST_DECODE: begin
          // Precompute the branch/JAL target (old PC + imm) into ALUOut.
          bus.alu_src_a = SRC_A_OLD_PC;
          bus.alu_src_b = SRC_B_IMM;
          state_next_s  = decode_target(bus.opcode);
          if (state_next_s == ST_HALT) begin
            fault_set_s       = 1'b1;
            fault_code_next_s = FAULT_ILLEGAL;
          end else begin
            fault_set_s = 1'b0;
          end
        end
        ST_EXEC: begin
          case (bus.opcode)
            OP_R_TYPE: begin
              bus.alu_src_a = SRC_A_RS1;
              bus.alu_op    = ALU_RTYPE;
            end
            OP_I_ALU: begin
              bus.alu_src_a = SRC_A_RS1;
              bus.alu_src_b = SRC_B_IMM;
              bus.alu_op    = ALU_ITYPE;
            end
            OP_LOAD, OP_STORE: begin
              bus.alu_src_a = SRC_A_RS1;
              bus.alu_src_b = SRC_B_IMM;
            end
            OP_LUI: begin
              bus.alu_src_a = SRC_A_ZERO;
              bus.alu_src_b = SRC_B_IMM;
            end
            OP_AUIPC: begin
              bus.alu_src_a = SRC_A_OLD_PC;
              bus.alu_src_b = SRC_B_IMM;
            end
            default: begin
              bus.alu_src_a = SRC_A_PC;
            end
          endcase
          if ((bus.opcode == OP_LOAD) || (bus.opcode == OP_STORE)) begin
            state_next_s = ST_MEM_ACC;
          end else begin
            state_next_s = ST_WB;
          end
        end
        ST_MEM_ACC: begin
          bus.mem_req  = 1'b1;
          bus.addr_sel = 1'b1;
          bus.mem_we   = (bus.opcode == OP_STORE);
          if (bus.mem_ready) begin
            if (bus.opcode == OP_STORE) begin
              retire_s     = 1'b1;
              state_next_s = ST_FETCH;
            end else begin
              state_next_s = ST_WB;
            end
          end else if (timeout_s) begin
            state_next_s      = ST_HALT;
            fault_set_s       = 1'b1;
            fault_code_next_s = FAULT_TIMEOUT;
          end else begin
            state_next_s = ST_MEM_ACC;
          end
        end
        ST_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = (bus.opcode == OP_LOAD) ? WB_MEM : WB_ALUOUT;
          retire_s       = 1'b1;
          state_next_s   = ST_FETCH;
        end
        ST_BRANCH: begin
          bus.alu_src_a = SRC_A_RS1;
          bus.alu_op    = ALU_BRANCH;
          if (bus.branch_cond) begin
            bus.pc_write = 1'b1;
            bus.pc_src   = PC_SRC_ALUOUT;
          end else begin
            bus.pc_write = 1'b0;
          end
          retire_s     = 1'b1;
          state_next_s = ST_FETCH;
        end
        ST_JUMP: begin
          // The link write and the PC update share one cycle, so JALR's
          // target is formed from rs1 before the register file updates.
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = WB_LINK;
          bus.pc_write   = 1'b1;
          if (bus.opcode == OP_JALR) begin
            bus.alu_src_a = SRC_A_RS1;
            bus.alu_src_b = SRC_B_IMM;
            bus.pc_src    = PC_SRC_ALU_LSB0;
          end else begin
            bus.pc_src = PC_SRC_ALUOUT;
          end
          retire_s     = 1'b1;
          state_next_s = ST_FETCH;
        end
        ST_HALT: begin
          state_next_s = ST_HALT;
        end
        default: begin
          state_next_s = ST_HALT;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      instret_r <= '0;
    end else if (retire_s) begin
      instret_r <= instret_r + CNT_W'(1);
    end else begin
      instret_r <= instret_r;
    end
  end

  // Sticky fault flag and code, captured on the transition into HALT.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_r      <= 1'b0;
      fault_code_r <= FAULT_NONE;
    end else if (fault_set_s) begin
      fault_r      <= 1'b1;
      fault_code_r <= fault_code_next_s;
    end else begin
      fault_r      <= fault_r;
      fault_code_r <= fault_code_r;
    end
  end

  assign bus.state      = state_r;
  assign bus.fault      = fault_r;
  assign bus.fault_code = fault_code_r;
  assign bus.instret    = instret_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
// Directed-vector bench for multicycle_controller (MEM_TIMEOUT = 4).
// Each cycle checks {state, mem_req, mem_we, addr_sel, ir_write, pc_write,
// reg_write, pc_src, alu_src_a, alu_src_b, alu_op, mem_to_reg} against a
// hand-written expected word.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  multicycle_controller_if #(.CNT_W(32)) bus ();

  multicycle_controller #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  logic [15:0] ctrl_obs;
  logic [19:0] word_obs;
  assign ctrl_obs = {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_write,
                     bus.pc_write, bus.reg_write, bus.pc_src, bus.alu_src_a,
                     bus.alu_src_b, bus.alu_op, bus.mem_to_reg};
  assign word_obs = {bus.state, ctrl_obs};

  // strb = {mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write}
  function automatic logic [19:0] w(input logic [3:0] st, input logic [5:0] strb,
                                    input logic [1:0] pcs, input logic [1:0] a,
                                    input logic [1:0] b, input logic [1:0] op,
                                    input logic [1:0] m2r);
    return {st, strb, pcs, a, b, op, m2r};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check the decoded word, advance past the edge.
  task automatic cyc(input string tag, input logic rdy, input logic bc,
                     input logic [19:0] exp);
    bus.mem_ready   = rdy;
    bus.branch_cond = bc;
    #1;
    chk(tag, {44'd0, word_obs}, {44'd0, exp});
    @(posedge clk);
    #1;
    bus.mem_ready   = 1'b0;
    bus.branch_cond = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset         = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    chk({tag, "_strobes"}, {48'd0, ctrl_obs}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk({tag, "_state"}, {60'd0, bus.state}, 64'd0);
    chk({tag, "_instret"}, {32'd0, bus.instret}, 64'd0);
    chk({tag, "_fault"}, {62'd0, bus.fault, 1'b0}, 64'd0);
    chk({tag, "_code"}, {62'd0, bus.fault_code}, 64'd0);
  endtask

  logic [19:0] FETCH, FETCH_RDY, DECODE, EX_R, EX_I, EX_MEM, EX_LUI, EX_AUIPC;
  logic [19:0] MEM_LD, MEM_ST, WB_ALU, WB_LD, BR_NT, BR_T, J_JAL, J_JALR, HALT;

  initial begin
    FETCH     = w(4'd0, 6'b100000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    FETCH_RDY = w(4'd0, 6'b100110, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    DECODE    = w(4'd1, 6'b000000, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00);
    EX_R      = w(4'd2, 6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00);
    EX_I      = w(4'd2, 6'b000000, 2'b00, 2'b10, 2'b10, 2'b11, 2'b00);
    EX_MEM    = w(4'd2, 6'b000000, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00);
    EX_LUI    = w(4'd2, 6'b000000, 2'b00, 2'b11, 2'b10, 2'b00, 2'b00);
    EX_AUIPC  = w(4'd2, 6'b000000, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00);
    MEM_LD    = w(4'd3, 6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    MEM_ST    = w(4'd3, 6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    WB_ALU    = w(4'd4, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    WB_LD     = w(4'd4, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
    BR_NT     = w(4'd5, 6'b000000, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00);
    BR_T      = w(4'd5, 6'b000010, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00);
    J_JAL     = w(4'd6, 6'b000011, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10);
    J_JALR    = w(4'd6, 6'b000011, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10);
    HALT      = w(4'd7, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    bus.opcode      = 7'h00;
    bus.branch_cond = 1'b0;
    bus.mem_ready   = 1'b0;
    do_reset("rst0");

    // ADD x0,x1,x2 (0x00208033): 4 cycles, retires on WB
    bus.opcode = 7'h33;
    cyc("add_fetch", 1'b1, 1'b0, FETCH_RDY);
    cyc("add_dec",   1'b0, 1'b0, DECODE);
    cyc("add_exec",  1'b0, 1'b0, EX_R);
    chk("add_instret_pre", {32'd0, bus.instret}, 64'd0);
    cyc("add_wb",    1'b0, 1'b0, WB_ALU);
    chk("add_instret", {32'd0, bus.instret}, 64'd1);

    // LW with three wait cycles in MEM_ACC: 8 cycles total
    bus.opcode = 7'h03;
    cyc("lw_fetch", 1'b1, 1'b0, FETCH_RDY);
    cyc("lw_dec",   1'b0, 1'b0, DECODE);
    cyc("lw_exec",  1'b0, 1'b0, EX_MEM);
    cyc("lw_mem_w1", 1'b0, 1'b0, MEM_LD);
    cyc("lw_mem_w2", 1'b0, 1'b0, MEM_LD);
    cyc("lw_mem_w3", 1'b0, 1'b0, MEM_LD);
    cyc("lw_mem_rdy", 1'b1, 1'b0, MEM_LD);
    cyc("lw_wb",    1'b0, 1'b0, WB_LD);
    chk("lw_instret", {32'd0, bus.instret}, 64'd2);

    // BEQ not taken, then taken
    bus.opcode = 7'h63;
    cyc("beq0_fetch", 1'b1, 1'b0, FETCH_RDY);
    cyc("beq0_dec",   1'b0, 1'b0, DECODE);
    cyc("beq0_br",    1'b0, 1'b0, BR_NT);
    chk("beq0_instret", {32'd0, bus.instret}, 64'd3);
    cyc("beq1_fetch", 1'b1, 1'b0, FETCH_RDY);
    cyc("beq1_dec",   1'b0, 1'b0, DECODE);
    cyc("beq1_br",    1'b0, 1'b1, BR_T);
    chk("beq1_instret", {32'd0, bus.instret}, 64'd4);

    // SW zero-wait: 4 cycles, retires out of MEM_ACC
    bus.opcode = 7'h23;
    cyc("sw_fetch", 1'b1, 1'b0, FETCH_RDY);
    cyc("sw_dec",   1'b0, 1'b0, DECODE);
    cyc("sw_exec",  1'b0, 1'b0, EX_MEM);
    cyc("sw_mem",   1'b1, 1'b0, MEM_ST);
    cyc("sw_next_fetch", 1'b0, 1'b0, FETCH);
    chk("sw_instret", {32'd0, bus.instret}, 64'd5);

    // I-ALU, LUI, AUIPC EXEC selects
    bus.opcode = 7'h13;
    cyc("i_fetch", 1'b1, 1'b0, FETCH_RDY);
    cyc("i_dec",   1'b0, 1'b0, DECODE);
    cyc("i_exec",  1'b0, 1'b0, EX_I);
    cyc("i_wb",    1'b0, 1'b0, WB_ALU);
    bus.opcode = 7'h37;
    cyc("lui_fetch", 1'b1, 1'b0, FETCH_RDY);
    cyc("lui_dec",   1'b0, 1'b0, DECODE);
    cyc("lui_exec",  1'b0, 1'b0, EX_LUI);
    cyc("lui_wb",    1'b0, 1'b0, WB_ALU);
    bus.opcode = 7'h17;
    cyc("auipc_fetch", 1'b1, 1'b0, FETCH_RDY);
    cyc("auipc_dec",   1'b0, 1'b0, DECODE);
    cyc("auipc_exec",  1'b0, 1'b0, EX_AUIPC);
    cyc("auipc_wb",    1'b0, 1'b0, WB_ALU);
    chk("alu_instret", {32'd0, bus.instret}, 64'd8);

    // JAL and JALR: 3 cycles each
    bus.opcode = 7'h6F;
    cyc("jal_fetch", 1'b1, 1'b0, FETCH_RDY);
    cyc("jal_dec",   1'b0, 1'b0, DECODE);
    cyc("jal_jump",  1'b0, 1'b0, J_JAL);
    bus.opcode = 7'h67;
    cyc("jalr_fetch", 1'b1, 1'b0, FETCH_RDY);
    cyc("jalr_dec",   1'b0, 1'b0, DECODE);
    cyc("jalr_jump",  1'b0, 1'b0, J_JALR);
    chk("jump_instret", {32'd0, bus.instret}, 64'd10);

    // mem_ready on the 4th (last permitted) FETCH cycle completes, no fault
    bus.opcode = 7'h6F;
    cyc("edge_fetch_w1", 1'b0, 1'b0, FETCH);
    cyc("edge_fetch_w2", 1'b0, 1'b0, FETCH);
    cyc("edge_fetch_w3", 1'b0, 1'b0, FETCH);
    cyc("edge_fetch_rdy", 1'b1, 1'b0, FETCH_RDY);
    cyc("edge_dec",  1'b0, 1'b0, DECODE);
    cyc("edge_jump", 1'b0, 1'b0, J_JAL);
    chk("edge_fault", {63'd0, bus.fault}, 64'd0);
    chk("edge_instret", {32'd0, bus.instret}, 64'd11);

    // Stray mem_ready outside FETCH/MEM_ACC is ignored
    bus.opcode = 7'h33;
    cyc("stray_fetch", 1'b1, 1'b0, FETCH_RDY);
    cyc("stray_dec",   1'b1, 1'b0, DECODE);
    cyc("stray_exec",  1'b1, 1'b0, EX_R);
    cyc("stray_wb",    1'b1, 1'b0, WB_ALU);
    chk("stray_instret", {32'd0, bus.instret}, 64'd12);

    // Reset in the middle of a LW memory access aborts it
    bus.opcode = 7'h03;
    cyc("abort_fetch", 1'b1, 1'b0, FETCH_RDY);
    cyc("abort_dec",   1'b0, 1'b0, DECODE);
    cyc("abort_exec",  1'b0, 1'b0, EX_MEM);
    cyc("abort_mem",   1'b0, 1'b0, MEM_LD);
    do_reset("rst_abort");
    cyc("abort_refetch", 1'b1, 1'b0, FETCH_RDY);
    cyc("abort_redec",   1'b0, 1'b0, DECODE);
    cyc("abort_reexec",  1'b0, 1'b0, EX_MEM);
    cyc("abort_remem",   1'b1, 1'b0, MEM_LD);
    cyc("abort_rewb",    1'b0, 1'b0, WB_LD);
    chk("abort_instret", {32'd0, bus.instret}, 64'd1);

    // FETCH timeout: 4 cycles without ready -> HALT, code 10
    bus.opcode = 7'h33;
    cyc("to_fetch_w1", 1'b0, 1'b0, FETCH);
    cyc("to_fetch_w2", 1'b0, 1'b0, FETCH);
    cyc("to_fetch_w3", 1'b0, 1'b0, FETCH);
    cyc("to_fetch_w4", 1'b0, 1'b0, FETCH);
    cyc("to_halt1",    1'b1, 1'b0, HALT);
    cyc("to_halt2",    1'b0, 1'b0, HALT);
    chk("to_fault", {63'd0, bus.fault}, 64'd1);
    chk("to_code",  {62'd0, bus.fault_code}, 64'd2);
    chk("to_instret", {32'd0, bus.instret}, 64'd1);
    do_reset("rst_to");

    // Illegal opcode 0x7F -> HALT, code 01, instret frozen
    bus.opcode = 7'h33;
    cyc("ill_pre_fetch", 1'b1, 1'b0, FETCH_RDY);
    cyc("ill_pre_dec",   1'b0, 1'b0, DECODE);
    cyc("ill_pre_exec",  1'b0, 1'b0, EX_R);
    cyc("ill_pre_wb",    1'b0, 1'b0, WB_ALU);
    bus.opcode = 7'h7F;
    cyc("ill_fetch", 1'b1, 1'b0, FETCH_RDY);
    cyc("ill_dec",   1'b0, 1'b0, DECODE);
    cyc("ill_halt1", 1'b1, 1'b0, HALT);
    cyc("ill_halt2", 1'b0, 1'b1, HALT);
    chk("ill_fault", {63'd0, bus.fault}, 64'd1);
    chk("ill_code",  {62'd0, bus.fault_code}, 64'd1);
    chk("ill_instret", {32'd0, bus.instret}, 64'd1);
    do_reset("rst_ill");
    cyc("ill_recover_fetch", 1'b0, 1'b0, FETCH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
